// File: rtl/fetch_ctrl.sv
// Small circular buffer with synchronous flush; head is visible combinationally.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_vld,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push_vld && !flush)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_vld)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push_vld) - CW'(pop_vld);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Instruction fetch: one outstanding 32-bit read, buffered with its PC for the decoder.
// Latency: request -> accept -> response -> dec_valid on the following cycle.
// Backpressure: requests are issued only while buffer count plus outstanding is below DEPTH.
module fetch_ctrl #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int FW = ADDR_W + 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt_after;
    logic              push;
    logic              pop;
    logic              req_acc;
    logic [FW-1:0]     head;

    assign req_acc   = (state == REQ) && mem_req_ready;
    assign push      = (state == WAIT) && mem_resp_valid && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    // Occupancy after this cycle's push/pop decides whether credit remains for another request.
    assign cnt_after = count + CW'(push) - CW'(pop);

    fifo #(.W(FW), .DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .rst      (reset),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat ({req_pc, mem_resp_data}),
        .pop_vld  (pop),
        .head_dat (head),
        .count    (count)
    );

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = mem_req_ready ? DRAIN : REQ;
                WAIT:    state_nxt = mem_resp_valid ? REQ : DRAIN;
                default: state_nxt = mem_resp_valid ? REQ : DRAIN;
            endcase
        end else begin
            case (state)
                IDLE:    if (cnt_after < CW'(DEPTH)) state_nxt = REQ;
                REQ:     if (mem_req_ready) state_nxt = WAIT;
                WAIT:    if (mem_resp_valid) state_nxt = (cnt_after < CW'(DEPTH)) ? REQ : IDLE;
                default: if (mem_resp_valid) state_nxt = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (req_acc) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
        end
    end

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = fetch_pc;
    assign dec_valid     = (count != '0);
    assign dec_instr     = dec_valid ? head[31:0] : 32'h0;
    assign dec_pc        = dec_valid ? head[FW-1:32] : {ADDR_W{1'b0}};
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with RESET_PC=0x1000, DEPTH=2 and an optional 1-cycle memory.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc;
    int          n_pop;
    logic        auto_mem;
    logic        acc_chk;
    logic        sb_on;
    logic [63:0] exp_req;
    logic [63:0] exp_pc;

    fetch_ctrl #(.ADDR_W(64), .RESET_PC(64'h1000), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then let the memory answer after the rising edge.
    task automatic tick();
        logic        acc;
        logic [63:0] a;
        @(negedge clk);
        acc = mem_req_valid && mem_req_ready;
        a   = mem_req_addr;
        if (acc) begin
            n_acc++;
            if (acc_chk) begin
                chk("req_addr", a, exp_req);
                exp_req += 64'd4;
            end
        end
        if (dec_valid && dec_ready) begin
            n_pop++;
            if (sb_on) begin
                chk("dec_pc", dec_pc, exp_pc);
                chk("dec_instr", {32'h0, dec_instr}, {32'h0, instr_of(exp_pc)});
                exp_pc += 64'd4;
            end
        end
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_resp_valid = acc;
            mem_resp_data  = acc ? instr_of(a) : 32'h0;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        dec_ready      = 1'b0;
        auto_mem       = 1'b0;
        acc_chk        = 1'b0;
        sb_on          = 1'b0;
        n_acc          = 0;
        n_pop          = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        // Reset state and first request timing
        chk("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("rst_req_addr", mem_req_addr, 64'h1000);
        chk("rst_dec_valid", {63'h0, dec_valid}, 64'h0);
        chk("rst_dec_instr", {32'h0, dec_instr}, 64'h0);
        chk("rst_dec_pc", dec_pc, 64'h0);

        mem_req_ready = 1'b1;
        dec_ready     = 1'b1;
        auto_mem      = 1'b1;
        acc_chk       = 1'b1;
        sb_on         = 1'b1;
        exp_req       = 64'h1000;
        exp_pc        = 64'h1000;
        tick();
        chk("first_req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("first_req_addr", mem_req_addr, 64'h1000);
        repeat (11) tick();
        chk("stream_accepts", 64'(n_acc), 64'd6);
        chk("stream_pops", 64'(n_pop), 64'd5);

        // Asynchronous reset in mid-operation
        reset = 1'b1;
        #1;
        chk("midrst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("midrst_req_addr", mem_req_addr, 64'h1000);
        chk("midrst_dec_valid", {63'h0, dec_valid}, 64'h0);

        // Decoder stalled: buffer fills after two requests, then one pop frees one credit
        do_reset();
        mem_req_ready = 1'b1;
        auto_mem      = 1'b1;
        acc_chk       = 1'b1;
        exp_req       = 64'h1000;
        repeat (10) tick();
        chk("full_accepts", 64'(n_acc), 64'd2);
        chk("full_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("full_dec_valid", {63'h0, dec_valid}, 64'h1);
        chk("full_dec_pc", dec_pc, 64'h1000);
        sb_on     = 1'b1;
        exp_pc    = 64'h1000;
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("credit_req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("credit_req_addr", mem_req_addr, 64'h1008);
        chk("credit_dec_pc", dec_pc, 64'h1004);
        repeat (2) tick();
        chk("refull_req_valid", {63'h0, mem_req_valid}, 64'h0);
        dec_ready = 1'b1;
        repeat (2) tick();
        chk("order_pops", 64'(n_pop), 64'd3);

        // Redirect while waiting; stale response three cycles later is dropped
        do_reset();
        mem_req_ready = 1'b1;
        dec_ready     = 1'b1;
        tick();
        chk("w_req_addr", mem_req_addr, 64'h1000);
        tick();
        chk("w_waiting", {63'h0, mem_req_valid}, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        tick();
        redirect_valid = 1'b0;
        chk("w_drain_dec_valid", {63'h0, dec_valid}, 64'h0);
        chk("w_drain_req_valid", {63'h0, mem_req_valid}, 64'h0);
        repeat (2) tick();
        chk("w_drain_hold", {63'h0, mem_req_valid}, 64'h0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        chk("w_stale_dec_valid", {63'h0, dec_valid}, 64'h0);
        chk("w_redir_req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("w_redir_req_addr", mem_req_addr, 64'h2000);
        tick();
        chk("w_after_acc_dec_valid", {63'h0, dec_valid}, 64'h0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = instr_of(64'h2000);
        tick();
        mem_resp_valid = 1'b0;
        chk("w_new_dec_valid", {63'h0, dec_valid}, 64'h1);
        chk("w_new_dec_pc", dec_pc, 64'h2000);
        chk("w_new_dec_instr", {32'h0, dec_instr}, {32'h0, instr_of(64'h2000)});

        // Redirect coinciding with request accept and decoder pop at count=1
        do_reset();
        mem_req_ready = 1'b1;
        auto_mem      = 1'b1;
        repeat (3) tick();
        chk("c_pre_dec_valid", {63'h0, dec_valid}, 64'h1);
        chk("c_pre_req_addr", mem_req_addr, 64'h1004);
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        tick();
        redirect_valid = 1'b0;
        chk("c_flush_dec_valid", {63'h0, dec_valid}, 64'h0);
        chk("c_drain_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("c_orphan_resp", {63'h0, mem_resp_valid}, 64'h1);
        mem_req_ready = 1'b0;
        tick();
        chk("c_drop_dec_valid", {63'h0, dec_valid}, 64'h0);
        chk("c_redir_req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("c_redir_req_addr", mem_req_addr, 64'h3000);

        // Stall with a redirect mid-stall, then address wrap past the top of memory
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("s_stall_valid", {63'h0, mem_req_valid}, 64'h1);
            chk("s_stall_addr", mem_req_addr, 64'h3000);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk("s_redir_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("s_redir_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_stall2_valid", {63'h0, mem_req_valid}, 64'h1);
            chk("s_stall2_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("wrap_waiting", {63'h0, mem_req_valid}, 64'h0);
        tick();
        chk("wrap_req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("wrap_req_addr", mem_req_addr, 64'h0);
        chk("wrap_dec_pc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_dec_instr", {32'h0, dec_instr}, {32'h0, instr_of(64'hFFFF_FFFF_FFFF_FFFC)});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the RV64 pipeline front end. It sequences 32-bit instruction reads from the memory port, one outstanding request at a time, starting from `RESET_PC`. Returned instructions are buffered with their PCs in a small FIFO and presented to the decoder over a valid/ready handshake. A branch/jump redirect flushes the buffer and discards any in-flight response.

## Interface
- `ADDR_W`, 64: PC/address width.
- `RESET_PC`, `64'h0`: first fetch address after reset.
- `DEPTH`, 2: instruction buffer entries (≥1, power of two).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in `ADDR_W`: new fetch PC. Bits [1:0] are forced to 0.
- `mem_req_valid` out 1: read request.
- `mem_req_ready` in 1: request accepted this cycle.
- `mem_req_addr` out `ADDR_W`: request address.
- `mem_resp_valid` in 1: response data valid; always accepted.
- `mem_resp_data` in 32: instruction word.
- `dec_valid` out 1: buffer head valid.
- `dec_ready` in 1: decoder consumes head.
- `dec_instr` out 32: head instruction.
- `dec_pc` out `ADDR_W`: head PC.

## Operation
- State: FSM {IDLE, REQ, WAIT, DRAIN}, `fetch_pc`, FIFO of {pc, instr}, `count` (0..DEPTH).
- Credit rule: a request may be issued only when `count` + outstanding < `DEPTH`. The buffer can therefore never overflow.
- FSM transitions:
  - IDLE: go to REQ when `count` < `DEPTH`.
  - REQ: `mem_req_valid`=1, `mem_req_addr`=`fetch_pc`.
    - On `mem_req_ready`: latch `req_pc`=`fetch_pc`, set `fetch_pc` += 4, go to WAIT.
  - WAIT: on `mem_resp_valid`, push {`req_pc`, `mem_resp_data`}. Then go to REQ if the post-push/pop `count` < `DEPTH`, else IDLE.
  - DRAIN: on `mem_resp_valid`, drop the data and go to REQ.
- Request stability: once asserted, `mem_req_valid` stays high until accepted. `mem_req_addr` may change only as a result of a redirect.
- Redirect (priority over all other events in the same cycle):
  - FIFO is cleared; a same-cycle pop and push are both void.
  - `fetch_pc` = {`redirect_pc`[ADDR_W-1:2], 2'b00}.
  - Next state:
    - From IDLE or REQ with `mem_req_ready`=0: REQ.
    - From REQ with `mem_req_ready`=1: DRAIN. The accepted request is orphaned.
    - From WAIT with no `mem_resp_valid`: DRAIN.
    - From WAIT with `mem_resp_valid`: REQ. The response is discarded.
    - From DRAIN: stay in DRAIN, or go to REQ if `mem_resp_valid`.
- Decoder side:
  - `dec_valid` = (`count` != 0); `dec_instr`/`dec_pc` = FIFO head.
  - Pop on `dec_valid && dec_ready`. Simultaneous push and pop is legal; `count` is unchanged.
- PC arithmetic: `fetch_pc` + 4 is modulo 2^`ADDR_W` and wraps to 0 silently.
- Unexpected responses: `mem_resp_valid` in IDLE or REQ is ignored.

## Timing
- Reset values: state=IDLE, `count`=0, `fetch_pc`=`RESET_PC`, `mem_req_valid`=0, `mem_req_addr`=`RESET_PC`, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0.
- First clock edge after reset deassertion: IDLE→REQ, so `mem_req_valid` rises one cycle after reset release.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). A response arriving later is ignored (IDLE).
- Response at cycle t → `dec_valid`=1 at t+1; a new request is also issued at t+1 if credit allows.
- Pop at cycle t, with the buffer previously full and FSM in IDLE → REQ at t+1.
- Redirect at cycle t → `dec_valid`=0 at t+1.
  - If nothing is outstanding, `mem_req_valid`=1 with the redirect address at t+1.
  - Otherwise, the redirect address is requested the cycle after the stale response.
- Sustained throughput: one instruction per (request latency + response latency + 1) cycles. Only one request is ever in flight.

## Test plan
- Reset with `RESET_PC`=`64'h1000`, 1-cycle memory, `dec_ready`=1 → `mem_req_addr` 0x1000, 0x1004, 0x1008, …; each `dec_pc` matches its `dec_instr`; no request before reset release +1 cycle.
- `dec_ready`=0, DEPTH=2 → exactly two requests issued, then FSM holds in IDLE with `mem_req_valid`=0. Raising `dec_ready` for one cycle → one new request the next cycle, and the FIFO order is preserved.
- Redirect to 0x2002 while in WAIT; stale response arrives 3 cycles later → stale data never appears on `dec_*`; next request address is 0x2000.
- Redirect in the same cycle as `mem_req_ready` and as a decoder pop with `count`=1 → `count`=0 next cycle, DRAIN entered, and the following response is dropped.
- `fetch_pc` = 0xFFFF_FFFF_FFFF_FFFC → the next request address is 0x0 with no error.
- `mem_req_ready` held low for 5 cycles → `mem_req_valid` and `mem_req_addr` stay stable. A redirect during the stall changes the address on the next cycle without `mem_req_valid` dropping.
